// File: rtl/csr_pkg.sv
// rtl/csr_pkg.sv - CSR opcodes, privilege encoding and implemented address map for csr_unit
package csr_pkg;

    typedef enum logic [2:0] {
        CSR_OP_RW  = 3'b001,
        CSR_OP_RS  = 3'b010,
        CSR_OP_RC  = 3'b011,
        CSR_OP_RWI = 3'b101,
        CSR_OP_RSI = 3'b110,
        CSR_OP_RCI = 3'b111
    } csr_op_t;

    typedef enum logic [1:0] {
        MODE_U = 2'b00,
        MODE_S = 2'b01,
        MODE_M = 2'b11
    } mode_t;

    localparam logic [11:0] CSR_NONE       = 12'h000;

    localparam logic [11:0] CSR_SSTATUS    = 12'h100;
    localparam logic [11:0] CSR_SIE        = 12'h104;
    localparam logic [11:0] CSR_STVEC      = 12'h105;
    localparam logic [11:0] CSR_SSCRATCH   = 12'h140;
    localparam logic [11:0] CSR_SEPC       = 12'h141;
    localparam logic [11:0] CSR_SCAUSE     = 12'h142;
    localparam logic [11:0] CSR_STVAL      = 12'h143;
    localparam logic [11:0] CSR_SIP        = 12'h144;
    localparam logic [11:0] CSR_SATP       = 12'h180;

    localparam logic [11:0] CSR_MSTATUS    = 12'h300;
    localparam logic [11:0] CSR_MISA       = 12'h301;
    localparam logic [11:0] CSR_MEDELEG    = 12'h302;
    localparam logic [11:0] CSR_MIDELEG    = 12'h303;
    localparam logic [11:0] CSR_MIE        = 12'h304;
    localparam logic [11:0] CSR_MTVEC      = 12'h305;
    localparam logic [11:0] CSR_MCOUNTEREN = 12'h306;
    localparam logic [11:0] CSR_MSCRATCH   = 12'h340;
    localparam logic [11:0] CSR_MEPC       = 12'h341;
    localparam logic [11:0] CSR_MCAUSE     = 12'h342;
    localparam logic [11:0] CSR_MTVAL      = 12'h343;
    localparam logic [11:0] CSR_MIP        = 12'h344;
    localparam logic [11:0] CSR_MVENDORID  = 12'hF11;
    localparam logic [11:0] CSR_MARCHID    = 12'hF12;
    localparam logic [11:0] CSR_MIMPID     = 12'hF13;
    localparam logic [11:0] CSR_MHARTID    = 12'hF14;

    localparam logic [11:0] CSR_MCYCLE     = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET   = 12'hB02;
    localparam logic [11:0] CSR_MCYCLEH    = 12'hB80;
    localparam logic [11:0] CSR_MINSTRETH  = 12'hB82;
    localparam logic [11:0] CSR_CYCLE      = 12'hC00;
    localparam logic [11:0] CSR_INSTRET    = 12'hC02;
    localparam logic [11:0] CSR_CYCLEH     = 12'hC80;
    localparam logic [11:0] CSR_INSTRETH   = 12'hC82;

    function automatic logic csr_is_counter(input logic [11:0] addr);
        case (addr)
            CSR_MCYCLE, CSR_MCYCLEH, CSR_MINSTRET, CSR_MINSTRETH,
            CSR_CYCLE, CSR_CYCLEH, CSR_INSTRET, CSR_INSTRETH: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic csr_implemented(input logic [11:0] addr, input logic has_counters);
        case (addr)
            CSR_SSTATUS, CSR_SIE, CSR_STVEC, CSR_SSCRATCH, CSR_SEPC,
            CSR_SCAUSE, CSR_STVAL, CSR_SIP, CSR_SATP,
            CSR_MSTATUS, CSR_MISA, CSR_MEDELEG, CSR_MIDELEG, CSR_MIE,
            CSR_MTVEC, CSR_MCOUNTEREN, CSR_MSCRATCH, CSR_MEPC, CSR_MCAUSE,
            CSR_MTVAL, CSR_MIP, CSR_MVENDORID, CSR_MARCHID, CSR_MIMPID,
            CSR_MHARTID: return 1'b1;
            default: return has_counters && csr_is_counter(addr);
        endcase
    endfunction

endpackage

// File: rtl/csr_unit_if.sv
// rtl/csr_unit_if.sv - execute-side CSR request, register file ports and rd write-back
interface csr_unit_if #(parameter int XLEN = 32);

    logic            valid_i;
    logic [2:0]      csr_op_i;
    logic [11:0]     csr_addr_i;
    logic [XLEN-1:0] rs1_data_i;
    logic [4:0]      rs1_idx_i;
    logic [4:0]      rd_idx_i;
    logic [1:0]      current_mode_i;
    logic            stall_i;
    logic            flush_i;
    logic            retire_i;
    logic [11:0]     csr_address_r_o;
    logic [XLEN-1:0] csr_data_i;
    logic [11:0]     csr_address_wb_o;
    logic [XLEN-1:0] csr_wb_o;
    logic            csr_we_o;
    logic [XLEN-1:0] rd_data_o;
    logic [4:0]      rd_idx_o;
    logic            rd_we_o;
    logic            illegal_o;

    modport slave (
        input  valid_i, csr_op_i, csr_addr_i, rs1_data_i, rs1_idx_i, rd_idx_i,
               current_mode_i, stall_i, flush_i, retire_i, csr_data_i,
        output csr_address_r_o, csr_address_wb_o, csr_wb_o, csr_we_o,
               rd_data_o, rd_idx_o, rd_we_o, illegal_o
    );

    modport master (
        output valid_i, csr_op_i, csr_addr_i, rs1_data_i, rs1_idx_i, rd_idx_i,
               current_mode_i, stall_i, flush_i, retire_i, csr_data_i,
        input  csr_address_r_o, csr_address_wb_o, csr_wb_o, csr_we_o,
               rd_data_o, rd_idx_o, rd_we_o, illegal_o
    );

endinterface

// File: rtl/csr_counters.sv
// rtl/csr_counters.sv - 64-bit mcycle/minstret with write-wins update and read mux
import csr_pkg::*;

module csr_counters (
    input  logic        clk,
    input  logic        rst,
    input  logic        retire_i,
    input  logic        wr_en_i,
    input  logic [11:0] wr_addr_i,
    input  logic [31:0] wr_data_i,
    input  logic [11:0] rd_addr_i,
    output logic        rd_hit_o,
    output logic [31:0] rd_data_o
);

    logic [63:0] mcycle_q, mcycle_d;
    logic [63:0] minstret_q, minstret_d;

    // A write replaces one half and drops that counter's increment; the other half keeps its value.
    always_comb begin
        mcycle_d   = mcycle_q + 64'd1;
        minstret_d = retire_i ? (minstret_q + 64'd1) : minstret_q;
        if (wr_en_i) begin
            case (wr_addr_i)
                CSR_MCYCLE:    mcycle_d   = {mcycle_q[63:32], wr_data_i};
                CSR_MCYCLEH:   mcycle_d   = {wr_data_i, mcycle_q[31:0]};
                CSR_MINSTRET:  minstret_d = {minstret_q[63:32], wr_data_i};
                CSR_MINSTRETH: minstret_d = {wr_data_i, minstret_q[31:0]};
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcycle_q   <= 64'd0;
            minstret_q <= 64'd0;
        end else begin
            mcycle_q   <= mcycle_d;
            minstret_q <= minstret_d;
        end
    end

    always_comb begin
        rd_hit_o  = 1'b1;
        rd_data_o = 32'd0;
        case (rd_addr_i)
            CSR_MCYCLE,    CSR_CYCLE:    rd_data_o = mcycle_q[31:0];
            CSR_MCYCLEH,   CSR_CYCLEH:   rd_data_o = mcycle_q[63:32];
            CSR_MINSTRET,  CSR_INSTRET:  rd_data_o = minstret_q[31:0];
            CSR_MINSTRETH, CSR_INSTRETH: rd_data_o = minstret_q[63:32];
            default:                     rd_hit_o  = 1'b0;
        endcase
    end

endmodule

// File: rtl/csr_unit.sv
// rtl/csr_unit.sv - Zicsr execute/write-back unit: decode, legality, forwarding, counters
import csr_pkg::*;

module csr_unit #(
    parameter int XLEN         = 32,
    parameter bit HAS_COUNTERS = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    csr_unit_if.slave  bus
);

    typedef enum logic {ST_IDLE, ST_W} state_t;

    state_t          state_q, state_d;
    logic            w_write_q, w_write_d;
    logic            w_illegal_q, w_illegal_d;
    logic [11:0]     w_addr_q, w_addr_d;
    logic [XLEN-1:0] w_old_q, w_old_d;
    logic [XLEN-1:0] w_new_q, w_new_d;
    logic [4:0]      w_rd_q, w_rd_d;

    csr_op_t         op;
    logic            op_known;
    logic            write_en;
    logic            illegal_e;
    logic            accept;
    logic            w_valid;
    logic            commit;
    logic            csr_we;
    logic            rd_we;
    logic [XLEN-1:0] operand;
    logic [XLEN-1:0] old_val;
    logic [XLEN-1:0] new_val;
    logic            cnt_hit;
    logic [XLEN-1:0] cnt_rdata;

    assign op      = csr_op_t'(bus.csr_op_i);
    assign w_valid = (state_q == ST_W);
    assign accept  = bus.valid_i && !bus.stall_i && !bus.flush_i;
    assign commit  = w_valid && w_write_q && !bus.stall_i && !bus.flush_i;
    assign operand = bus.csr_op_i[2] ? {{(XLEN-5){1'b0}}, bus.rs1_idx_i} : bus.rs1_data_i;

    always_comb begin
        if (w_valid && w_write_q && (w_addr_q == bus.csr_addr_i)) begin
            old_val = w_new_q;
        end else if (cnt_hit) begin
            old_val = cnt_rdata;
        end else begin
            old_val = bus.csr_data_i;
        end
    end

    always_comb begin
        op_known = 1'b1;
        write_en = 1'b1;
        new_val  = operand;
        case (op)
            CSR_OP_RW, CSR_OP_RWI: new_val = operand;
            CSR_OP_RS, CSR_OP_RSI: begin
                new_val  = old_val | operand;
                write_en = (bus.rs1_idx_i != 5'd0);
            end
            CSR_OP_RC, CSR_OP_RCI: begin
                new_val  = old_val & ~operand;
                write_en = (bus.rs1_idx_i != 5'd0);
            end
            default: begin
                op_known = 1'b0;
                write_en = 1'b0;
                new_val  = old_val;
            end
        endcase
    end

    // Privilege lives in addr[9:8], read-only space is addr[11:10] == 2'b11.
    assign illegal_e = !op_known
                    || (bus.csr_addr_i[9:8] > bus.current_mode_i)
                    || (write_en && (bus.csr_addr_i[11:10] == 2'b11))
                    || !csr_implemented(bus.csr_addr_i, HAS_COUNTERS);

    always_comb begin
        state_d     = state_q;
        w_write_d   = w_write_q;
        w_illegal_d = w_illegal_q;
        w_addr_d    = w_addr_q;
        w_old_d     = w_old_q;
        w_new_d     = w_new_q;
        w_rd_d      = w_rd_q;
        if (bus.flush_i) begin
            state_d = ST_IDLE;
        end else if (w_valid && bus.stall_i) begin
            state_d = ST_W;
        end else if (accept) begin
            state_d     = ST_W;
            w_write_d   = write_en && !illegal_e;
            w_illegal_d = illegal_e;
            w_addr_d    = bus.csr_addr_i;
            w_old_d     = old_val;
            w_new_d     = new_val;
            w_rd_d      = bus.rd_idx_i;
        end else begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            w_write_q   <= 1'b0;
            w_illegal_q <= 1'b0;
            w_addr_q    <= CSR_NONE;
            w_old_q     <= '0;
            w_new_q     <= '0;
            w_rd_q      <= 5'd0;
        end else begin
            state_q     <= state_d;
            w_write_q   <= w_write_d;
            w_illegal_q <= w_illegal_d;
            w_addr_q    <= w_addr_d;
            w_old_q     <= w_old_d;
            w_new_q     <= w_new_d;
            w_rd_q      <= w_rd_d;
        end
    end

    generate
        if (HAS_COUNTERS) begin : g_counters
            csr_counters u_counters (
                .clk       (clk),
                .rst       (rst),
                .retire_i  (bus.retire_i),
                .wr_en_i   (commit),
                .wr_addr_i (w_addr_q),
                .wr_data_i (w_new_q),
                .rd_addr_i (bus.csr_addr_i),
                .rd_hit_o  (cnt_hit),
                .rd_data_o (cnt_rdata)
            );
        end else begin : g_no_counters
            assign cnt_hit   = 1'b0;
            assign cnt_rdata = '0;
        end
    endgenerate

    // The register file has no enable; idle cycles present CSR_NONE so nothing matches.
    assign csr_we               = commit && !csr_is_counter(w_addr_q);
    assign rd_we                = w_valid && !w_illegal_q && (w_rd_q != 5'd0) && !bus.flush_i;

    assign bus.csr_address_r_o  = rst ? CSR_NONE : bus.csr_addr_i;
    assign bus.csr_we_o         = csr_we;
    assign bus.csr_address_wb_o = csr_we ? w_addr_q : CSR_NONE;
    assign bus.csr_wb_o         = csr_we ? w_new_q : '0;
    assign bus.rd_we_o          = rd_we;
    assign bus.rd_data_o        = rd_we ? w_old_q : '0;
    assign bus.rd_idx_o         = rd_we ? w_rd_q : 5'd0;
    assign bus.illegal_o        = w_valid && w_illegal_q;

endmodule

// File: tb/tb_csr_unit.sv
// tb/tb_csr_unit.sv - self-checking bench for csr_unit with directed and randomized CSR traffic
module tb_csr_unit;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    csr_unit_if #(.XLEN(32)) bus ();

    csr_unit #(.XLEN(32), .HAS_COUNTERS(1'b1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [31:0] rf   [4096] = '{default: 32'h0};
    logic [31:0] arch [4096];

    assign bus.csr_data_i = rf[bus.csr_address_r_o];

    always @(posedge clk) begin
        if (bus.csr_we_o) rf[bus.csr_address_wb_o] <= bus.csr_wb_o;
    end

    task automatic drive_e(input logic [2:0] op, input logic [11:0] addr, input logic [31:0] rs1,
                           input logic [4:0] idx, input logic [4:0] rd, input logic [1:0] mode);
        bus.valid_i        = 1'b1;
        bus.csr_op_i       = op;
        bus.csr_addr_i     = addr;
        bus.rs1_data_i     = rs1;
        bus.rs1_idx_i      = idx;
        bus.rd_idx_i       = rd;
        bus.current_mode_i = mode;
    endtask

    task automatic idle_e();
        bus.valid_i        = 1'b0;
        bus.csr_op_i       = 3'b000;
        bus.csr_addr_i     = 12'h000;
        bus.rs1_data_i     = 32'h0;
        bus.rs1_idx_i      = 5'd0;
        bus.rd_idx_i       = 5'd0;
        bus.current_mode_i = 2'b11;
    endtask

    function automatic bit tb_implemented(input logic [11:0] a);
        case (a)
            12'h140, 12'h340, 12'h341, 12'h105, 12'h301,
            12'hF14, 12'h305, 12'h300, 12'h144: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic test_reset();
        @(negedge clk);
        checks++; if (bus.csr_we_o !== 1'b0) begin errors++; $display("FAIL reset_we got %0h want 0", bus.csr_we_o); end
        checks++; if (bus.csr_address_wb_o !== 12'h000) begin errors++; $display("FAIL reset_wb_addr got %0h want 000", bus.csr_address_wb_o); end
        checks++; if (bus.rd_we_o !== 1'b0) begin errors++; $display("FAIL reset_rd_we got %0h want 0", bus.rd_we_o); end
        checks++; if (bus.rd_data_o !== 32'h0) begin errors++; $display("FAIL reset_rd_data got %0h want 0", bus.rd_data_o); end
        checks++; if (bus.illegal_o !== 1'b0) begin errors++; $display("FAIL reset_illegal got %0h want 0", bus.illegal_o); end
        rst = 1'b0;
    endtask

    task automatic test_write_read();
        @(negedge clk); drive_e(3'b001, 12'h305, 32'h8000_0100, 5'd7, 5'd5, 2'b11);
        @(negedge clk);
        checks++; if (bus.csr_we_o !== 1'b1) begin errors++; $display("FAIL rw_we got %0h want 1", bus.csr_we_o); end
        checks++; if (bus.csr_address_wb_o !== 12'h305) begin errors++; $display("FAIL rw_addr got %0h want 305", bus.csr_address_wb_o); end
        checks++; if (bus.csr_wb_o !== 32'h8000_0100) begin errors++; $display("FAIL rw_data got %0h want 80000100", bus.csr_wb_o); end
        checks++; if (bus.rd_we_o !== 1'b1) begin errors++; $display("FAIL rw_rd_we got %0h want 1", bus.rd_we_o); end
        checks++; if (bus.rd_data_o !== 32'h0) begin errors++; $display("FAIL rw_rd_data got %0h want 0", bus.rd_data_o); end
        checks++; if (bus.rd_idx_o !== 5'd5) begin errors++; $display("FAIL rw_rd_idx got %0d want 5", bus.rd_idx_o); end
        arch[12'h305] = 32'h8000_0100;
        idle_e();
        @(negedge clk); drive_e(3'b010, 12'h305, 32'hFFFF_FFFF, 5'd0, 5'd6, 2'b11);
        @(negedge clk);
        checks++; if (bus.rd_data_o !== 32'h8000_0100) begin errors++; $display("FAIL readback got %0h want 80000100", bus.rd_data_o); end
        checks++; if (bus.csr_we_o !== 1'b0) begin errors++; $display("FAIL readback_we got %0h want 0", bus.csr_we_o); end
        idle_e();
    endtask

    task automatic test_set_clear();
        @(negedge clk); drive_e(3'b001, 12'h300, 32'h8, 5'd1, 5'd0, 2'b11);
        @(negedge clk);
        checks++; if (bus.csr_wb_o !== 32'h8) begin errors++; $display("FAIL init_mstatus got %0h want 8", bus.csr_wb_o); end
        checks++; if (bus.rd_we_o !== 1'b0) begin errors++; $display("FAIL rd0_we got %0h want 0", bus.rd_we_o); end
        drive_e(3'b010, 12'h300, 32'h80, 5'd1, 5'd3, 2'b11);
        @(negedge clk);
        checks++; if (bus.csr_wb_o !== 32'h88) begin errors++; $display("FAIL rs_data got %0h want 88", bus.csr_wb_o); end
        checks++; if (bus.rd_data_o !== 32'h8) begin errors++; $display("FAIL rs_fwd_old got %0h want 8", bus.rd_data_o); end
        drive_e(3'b011, 12'h300, 32'h8, 5'd1, 5'd4, 2'b11);
        @(negedge clk);
        checks++; if (bus.csr_wb_o !== 32'h80) begin errors++; $display("FAIL rc_data got %0h want 80", bus.csr_wb_o); end
        checks++; if (bus.rd_data_o !== 32'h88) begin errors++; $display("FAIL rc_fwd_old got %0h want 88", bus.rd_data_o); end
        checks++; if (bus.csr_we_o !== 1'b1) begin errors++; $display("FAIL rc_we got %0h want 1", bus.csr_we_o); end
        arch[12'h300] = 32'h80;
        idle_e();
    endtask

    task automatic test_read_only();
        @(negedge clk); drive_e(3'b010, 12'hF14, 32'h0, 5'd0, 5'd1, 2'b11);
        @(negedge clk);
        checks++; if (bus.csr_we_o !== 1'b0) begin errors++; $display("FAIL hartid_rd_we got %0h want 0", bus.csr_we_o); end
        checks++; if (bus.rd_data_o !== 32'h0) begin errors++; $display("FAIL hartid_rd got %0h want 0", bus.rd_data_o); end
        checks++; if (bus.rd_we_o !== 1'b1) begin errors++; $display("FAIL hartid_rdwe got %0h want 1", bus.rd_we_o); end
        checks++; if (bus.illegal_o !== 1'b0) begin errors++; $display("FAIL hartid_read_ill got %0h want 0", bus.illegal_o); end
        drive_e(3'b001, 12'hF14, 32'h5, 5'd2, 5'd2, 2'b11);
        @(negedge clk);
        checks++; if (bus.illegal_o !== 1'b1) begin errors++; $display("FAIL hartid_write_ill got %0h want 1", bus.illegal_o); end
        checks++; if (bus.csr_we_o !== 1'b0) begin errors++; $display("FAIL hartid_write_we got %0h want 0", bus.csr_we_o); end
        checks++; if (bus.rd_we_o !== 1'b0) begin errors++; $display("FAIL hartid_write_rdwe got %0h want 0", bus.rd_we_o); end
        idle_e();
    endtask

    task automatic test_privilege();
        @(negedge clk); drive_e(3'b010, 12'h300, 32'h1, 5'd1, 5'd5, 2'b00);
        @(negedge clk);
        checks++; if (bus.illegal_o !== 1'b1) begin errors++; $display("FAIL priv_u_ill got %0h want 1", bus.illegal_o); end
        checks++; if (bus.csr_we_o !== 1'b0) begin errors++; $display("FAIL priv_u_we got %0h want 0", bus.csr_we_o); end
        drive_e(3'b010, 12'h100, 32'h0, 5'd0, 5'd7, 2'b01);
        @(negedge clk);
        checks++; if (bus.illegal_o !== 1'b0) begin errors++; $display("FAIL priv_s_ill got %0h want 0", bus.illegal_o); end
        checks++; if (bus.rd_we_o !== 1'b1) begin errors++; $display("FAIL priv_s_rdwe got %0h want 1", bus.rd_we_o); end
        idle_e();
    endtask

    task automatic test_stall();
        int we_hits = 0;
        @(negedge clk); drive_e(3'b001, 12'h341, 32'h1234, 5'd1, 5'd9, 2'b11);
        @(negedge clk); idle_e(); bus.stall_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            if (bus.csr_we_o === 1'b1) we_hits++;
            checks++; if (bus.csr_we_o !== 1'b0) begin errors++; $display("FAIL stall_we cyc %0d got %0h want 0", i, bus.csr_we_o); end
            @(negedge clk);
        end
        bus.stall_i = 1'b0;
        #1;
        if (bus.csr_we_o === 1'b1) we_hits++;
        checks++; if (bus.csr_we_o !== 1'b1 || bus.csr_address_wb_o !== 12'h341 || bus.csr_wb_o !== 32'h1234) begin
            errors++; $display("FAIL unstall_write got we=%0h addr=%0h data=%0h want 1/341/1234", bus.csr_we_o, bus.csr_address_wb_o, bus.csr_wb_o);
        end
        @(negedge clk); #1;
        if (bus.csr_we_o === 1'b1) we_hits++;
        checks++; if (we_hits !== 1) begin errors++; $display("FAIL stall_once got %0d writes want 1", we_hits); end
        arch[12'h341] = 32'h1234;
    endtask

    task automatic test_flush();
        @(negedge clk); drive_e(3'b001, 12'h340, 32'hDEAD, 5'd1, 5'd10, 2'b11);
        @(negedge clk); bus.flush_i = 1'b1; drive_e(3'b001, 12'h340, 32'hBEEF, 5'd1, 5'd11, 2'b11);
        #1;
        checks++; if (bus.csr_we_o !== 1'b0) begin errors++; $display("FAIL flush_we got %0h want 0", bus.csr_we_o); end
        checks++; if (bus.rd_we_o !== 1'b0) begin errors++; $display("FAIL flush_rdwe got %0h want 0", bus.rd_we_o); end
        @(negedge clk); bus.flush_i = 1'b0; idle_e();
        #1;
        checks++; if (bus.csr_we_o !== 1'b0 || bus.rd_we_o !== 1'b0) begin
            errors++; $display("FAIL flush_blocked got we=%0h rdwe=%0h want 0/0", bus.csr_we_o, bus.rd_we_o);
        end
        @(negedge clk); drive_e(3'b010, 12'h340, 32'h0, 5'd0, 5'd12, 2'b11);
        @(negedge clk);
        checks++; if (bus.rd_data_o !== 32'h0) begin errors++; $display("FAIL flush_mscratch got %0h want 0", bus.rd_data_o); end
        idle_e();
    endtask

    task automatic test_reset_mid();
        @(negedge clk); drive_e(3'b001, 12'h144, 32'h55, 5'd1, 5'd13, 2'b11);
        @(negedge clk); #1 rst = 1'b1; #1;
        checks++; if ({bus.csr_we_o, bus.csr_address_wb_o, bus.csr_wb_o} !== 45'h0) begin
            errors++; $display("FAIL rstmid_wb got we=%0h addr=%0h data=%0h want 0", bus.csr_we_o, bus.csr_address_wb_o, bus.csr_wb_o);
        end
        checks++; if ({bus.rd_we_o, bus.rd_data_o, bus.rd_idx_o, bus.illegal_o} !== 39'h0) begin
            errors++; $display("FAIL rstmid_rd got rdwe=%0h data=%0h idx=%0d ill=%0h want 0", bus.rd_we_o, bus.rd_data_o, bus.rd_idx_o, bus.illegal_o);
        end
        checks++; if (bus.csr_address_r_o !== 12'h000) begin errors++; $display("FAIL rstmid_raddr got %0h want 0", bus.csr_address_r_o); end
        idle_e();
        @(negedge clk); rst = 1'b0;
        @(negedge clk); drive_e(3'b010, 12'h144, 32'h0, 5'd0, 5'd1, 2'b11);
        @(negedge clk);
        checks++; if (bus.rd_data_o !== 32'h0) begin errors++; $display("FAIL rstmid_dropped got %0h want 0", bus.rd_data_o); end
        idle_e();
    endtask

    task automatic test_counters();
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        repeat (10) @(negedge clk);
        drive_e(3'b010, 12'hB00, 32'h0, 5'd0, 5'd1, 2'b11);
        @(negedge clk);
        checks++; if (bus.rd_data_o !== 32'd10) begin errors++; $display("FAIL mcycle got %0d want 10", bus.rd_data_o); end
        checks++; if (bus.csr_we_o !== 1'b0) begin errors++; $display("FAIL mcycle_we got %0h want 0", bus.csr_we_o); end
        drive_e(3'b010, 12'hB80, 32'h0, 5'd0, 5'd2, 2'b11);
        @(negedge clk);
        checks++; if (bus.rd_data_o !== 32'd0) begin errors++; $display("FAIL mcycleh got %0h want 0", bus.rd_data_o); end
        drive_e(3'b001, 12'hB02, 32'hFFFF_FFFF, 5'd3, 5'd4, 2'b11); bus.retire_i = 1'b1;
        @(negedge clk);
        checks++; if (bus.rd_data_o !== 32'd0) begin errors++; $display("FAIL minstret_old got %0h want 0", bus.rd_data_o); end
        checks++; if (bus.csr_we_o !== 1'b0 || bus.csr_address_wb_o !== 12'h000) begin
            errors++; $display("FAIL minstret_rfwe got we=%0h addr=%0h want 0/000", bus.csr_we_o, bus.csr_address_wb_o);
        end
        idle_e();
        @(negedge clk); bus.retire_i = 1'b0; drive_e(3'b010, 12'hB02, 32'h0, 5'd0, 5'd1, 2'b11);
        @(negedge clk);
        checks++; if (bus.rd_data_o !== 32'hFFFF_FFFF) begin errors++; $display("FAIL minstret_wr got %0h want ffffffff", bus.rd_data_o); end
        drive_e(3'b010, 12'hB82, 32'h0, 5'd0, 5'd2, 2'b11);
        @(negedge clk);
        checks++; if (bus.rd_data_o !== 32'h0) begin errors++; $display("FAIL minstreth_wr got %0h want 0", bus.rd_data_o); end
        idle_e(); bus.retire_i = 1'b1;
        @(negedge clk); bus.retire_i = 1'b0; drive_e(3'b010, 12'hB82, 32'h0, 5'd0, 5'd3, 2'b11);
        @(negedge clk);
        checks++; if (bus.rd_data_o !== 32'h1) begin errors++; $display("FAIL minstreth_carry got %0h want 1", bus.rd_data_o); end
        drive_e(3'b010, 12'hB02, 32'h0, 5'd0, 5'd4, 2'b11);
        @(negedge clk);
        checks++; if (bus.rd_data_o !== 32'h0) begin errors++; $display("FAIL minstret_carry got %0h want 0", bus.rd_data_o); end
        drive_e(3'b010, 12'hC82, 32'h0, 5'd0, 5'd5, 2'b00);
        @(negedge clk);
        checks++; if (bus.rd_data_o !== 32'h1 || bus.illegal_o !== 1'b0) begin
            errors++; $display("FAIL instreth_user got %0h ill=%0h want 1/0", bus.rd_data_o, bus.illegal_o);
        end
        drive_e(3'b001, 12'hC00, 32'h7, 5'd1, 5'd6, 2'b11);
        @(negedge clk);
        checks++; if (bus.illegal_o !== 1'b1) begin errors++; $display("FAIL cycle_write_ill got %0h want 1", bus.illegal_o); end
        idle_e();
    endtask

    task automatic test_random();
        logic [11:0] addrs [9] = '{12'h140, 12'h340, 12'h341, 12'h105, 12'h301, 12'hF14, 12'h7C0, 12'h144, 12'h305};
        logic [2:0]  ops   [6] = '{3'b001, 3'b010, 3'b011, 3'b101, 3'b110, 3'b111};
        bit          have_prev = 1'b0;
        logic        e_we, e_rdwe, e_ill;
        logic [11:0] e_addr;
        logic [31:0] e_wb, e_rd;
        logic [4:0]  e_rdidx;
        for (int i = 0; i <= 200; i++) begin
            @(negedge clk);
            if (have_prev) begin
                checks++; if (bus.csr_we_o !== e_we) begin errors++; $display("FAIL rnd%0d_we got %0h want %0h", i, bus.csr_we_o, e_we); end
                checks++; if (bus.csr_address_wb_o !== (e_we ? e_addr : 12'h000)) begin
                    errors++; $display("FAIL rnd%0d_addr got %0h want %0h", i, bus.csr_address_wb_o, e_we ? e_addr : 12'h000);
                end
                if (e_we) begin
                    checks++; if (bus.csr_wb_o !== e_wb) begin errors++; $display("FAIL rnd%0d_wb got %0h want %0h", i, bus.csr_wb_o, e_wb); end
                end
                checks++; if (bus.rd_we_o !== e_rdwe) begin errors++; $display("FAIL rnd%0d_rdwe got %0h want %0h", i, bus.rd_we_o, e_rdwe); end
                if (e_rdwe) begin
                    checks++; if (bus.rd_data_o !== e_rd || bus.rd_idx_o !== e_rdidx) begin
                        errors++; $display("FAIL rnd%0d_rd got %0h/x%0d want %0h/x%0d", i, bus.rd_data_o, bus.rd_idx_o, e_rd, e_rdidx);
                    end
                end
                checks++; if (bus.illegal_o !== e_ill) begin errors++; $display("FAIL rnd%0d_ill got %0h want %0h", i, bus.illegal_o, e_ill); end
            end
            if (i < 200) begin
                logic [11:0] a;
                logic [2:0]  op;
                logic [31:0] rs1, s, oldv, newv;
                logic [4:0]  idx, rd;
                logic [1:0]  mode;
                bit          wr, legal;
                a    = addrs[$urandom_range(0, 8)];
                op   = ops[$urandom_range(0, 5)];
                rs1  = $urandom;
                idx  = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                rd   = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                case ($urandom_range(0, 2))
                    0:       mode = 2'b00;
                    1:       mode = 2'b01;
                    default: mode = 2'b11;
                endcase
                s     = op[2] ? {27'd0, idx} : rs1;
                oldv  = arch[a];
                wr    = (op[1:0] == 2'b01) || (idx != 5'd0);
                legal = tb_implemented(a) && (mode >= a[9:8]) && !(wr && a[11:10] == 2'b11);
                case (op[1:0])
                    2'b01:   newv = s;
                    2'b10:   newv = oldv | s;
                    default: newv = oldv & ~s;
                endcase
                e_we    = legal && wr;
                e_addr  = a;
                e_wb    = newv;
                e_rdwe  = legal && (rd != 5'd0);
                e_rd    = oldv;
                e_rdidx = rd;
                e_ill   = !legal;
                if (e_we) arch[a] = newv;
                drive_e(op, a, rs1, idx, rd, mode);
                have_prev = 1'b1;
            end else begin
                idle_e();
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) arch[i] = 32'h0;
        idle_e();
        bus.stall_i  = 1'b0;
        bus.flush_i  = 1'b0;
        bus.retire_i = 1'b0;
        test_reset();
        test_write_read();
        test_set_clear();
        test_read_only();
        test_privilege();
        test_stall();
        test_flush();
        test_reset_mid();
        test_counters();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/csr_unit.md
Name: csr_unit

Overview:
- Execute-side CSR access unit: decodes Zicsr ops (CSRRW/S/C and immediate forms) and reads the old value through the CSR register file read port.
- Computes the new value and drives the register file write-back port one cycle later, returning the old value to rd.
- Owns the mcycle/minstret counters, which the register file does not hold.
- Checks access legality (read-only, privilege, unimplemented) and flags illegal instructions to the trap path.

Parameters:
- XLEN, 32, data width.
- HAS_COUNTERS, 1, instantiate mcycle/minstret (0: counter addresses are illegal).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- valid_i  in  1  CSR instruction present in execute this cycle
- csr_op_i  in  3  funct3: 001 RW, 010 RS, 011 RC, 101 RWI, 110 RSI, 111 RCI
- csr_addr_i  in  12  CSR address
- rs1_data_i  in  32  rs1 operand
- rs1_idx_i  in  5  rs1 index; zimm for immediate forms
- rd_idx_i  in  5  destination register
- current_mode_i  in  2  privilege (U=00, S=01, M=11)
- stall_i  in  1  pipeline stall
- flush_i  in  1  exception_pending/trap flush
- retire_i  in  1  one instruction retired this cycle
- csr_address_r_o  out  12  register file read address
- csr_data_i  in  32  register file read data
- csr_address_wb_o  out  12  register file write address
- csr_wb_o  out  32  register file write data
- csr_we_o  out  1  write strobe
- rd_data_o  out  32  old CSR value to rd
- rd_idx_o  out  5  rd index
- rd_we_o  out  1  rd write enable
- illegal_o  out  1  illegal CSR access, one-cycle pulse

Behaviour:
Reset values:
- All outputs 0.
- csr_address_wb_o = 12'h000 (CSR_NONE).
- W stage invalid.
- mcycle = minstret = 0.

Pipeline (E then W):
- E stage: csr_address_r_o = csr_addr_i combinationally. The old value comes from the first matching source, in this order:
  - forward from W when W is valid, writing, and at the same address;
  - internal counter;
  - csr_data_i.
- New value, with operand S = rs1_data_i for RW/RS/RC and S = zero-extended zimm for the immediate forms:
  - RW: S
  - RS: old | S
  - RC: old & ~S
- write_en = 0 for RS/RC/RSI/RCI when rs1_idx_i == 0. RW/RWI always write.
- E results are registered into W when valid_i && !stall_i && !flush_i.

Legality (checked in E):
- Illegal when any of:
  - csr_addr_i[9:8] > current_mode_i;
  - write_en && csr_addr_i[11:10] == 2'b11;
  - address not in the implemented set held in csr_pkg.
- On an illegal access, W is loaded with illegal = 1 and no write, no rd.

W stage, for exactly one non-stalled cycle:
- csr_we_o = w_valid && w_write && !stall_i && !flush_i.
- csr_address_wb_o / csr_wb_o are driven with the W values.
- rd_we_o = w_valid && !w_illegal && rd != 0 && !flush_i, with rd_data_o = old value.
- illegal_o = w_valid && w_illegal.
- When csr_we_o = 0, csr_address_wb_o = CSR_NONE. The register file has no enable, so it must see a non-matching address.

FSM: IDLE -> W on accept.
- W -> IDLE when there is no new accept.
- W -> W on a back-to-back accept.
- W holds while stall_i.
- flush_i clears W at the next edge and blocks accept.

Counters: 64-bit, wrapping at 2^64-1 to 0.
- mcycle increments every cycle.
- minstret increments on retire_i.
- A W-stage write to mcycle/mcycleh/minstret/minstreth replaces that half and suppresses that counter's increment that cycle (write wins). The other half is untouched.
- Counter writes are not forwarded to the register file; csr_we_o stays 0.
- The user-mode aliases cycle/cycleh/instret/instreth are readable and read-only.

Reset mid-operation: W is dropped with no write; counters clear.

Decomposition:
- csr_pkg holds:
  - csr_op_t enum;
  - CSR_NONE;
  - the implemented-address list, reusing the CSR_* constants from define.sv, plus CSR_MCYCLE(H), CSR_MINSTRET(H), CSR_CYCLE(H), CSR_INSTRET(H);
  - a mode encoding consistent with mode::mode_t.
- Sub-module csr_counters holds the two 64-bit counters, the write-wins logic and the read mux.

Test Plan:
- Write then read back: CSRRW mtvec, rs1 = 0x8000_0100, rd = 5, old value 0.
  - Required: next cycle csr_we_o = 1, csr_address_wb_o = 0x305, csr_wb_o = 0x8000_0100; rd_data_o = 0, rd_we_o = 1.
- Set/clear with forwarding:
  - mstatus = 0x8. Back-to-back CSRRS mstatus rs1 = 0x80, then CSRRC mstatus rs1 = 0x8.
  - Required writes: 0x88, then 0x80. Second rd_data_o = 0x88 (forwarded).
- Read-only checks:
  - CSRRS x1, mhartid, x0: no write, rd_data_o = 0, illegal_o = 0.
  - CSRRW mhartid, x2: illegal_o = 1, csr_we_o = 0, rd_we_o = 0.
- Privilege check: current_mode = U, CSRRS mstatus.
  - Required: illegal_o = 1, no write.
- Counters:
  - 10 cycles after reset, CSRRS mcycle, x0: rd_data_o = 10 ± pipeline offset (exact value fixed in bench).
  - CSRRW minstret = 0xFFFF_FFFF with retire_i high: minstret = 0x0000_0000_FFFF_FFFF, no increment that cycle.
  - Next retire: minstret = 0x1_0000_0000.
- Stall/flush:
  - stall_i held 3 cycles during W: csr_we_o stays 0, then asserts exactly once.
  - flush_i in W: no csr_we_o, no rd_we_o.
  - rst asserted mid-W: all outputs 0 immediately.
